// File: rtl/sr_ff_access_arbiter.sv
// sr_ff_access_arbiter
//
// Round-robin arbiter and write sequencer that lets NREQ requesters share
// one clocked SR flip-flop. One requester is granted at a time. The block
// drives S or R for exactly one clock and reads Q back to confirm the write.
// On a mismatch it retries up to MAX_RETRY extra times, then finishes with
// an ack pulse, plus an err pulse if the write never took.
// S and R are never driven high together.
//
// Ports
//   clk    rising-edge clock, shared with the flip-flop
//   rst    synchronous, active-high reset
//   req    per-requester request, held high until its ack
//   op     per-requester operation (1 = set, 0 = clear), stable while req high
//   Q      flip-flop output, used for read-back
//   S, R   registered drive to the flip-flop
//   grant  one-hot owner of the current transaction, zero when idle
//   ack    registered one-cycle completion pulse to the owner
//   err    one-cycle pulse alongside ack when read-back failed after retries
//   busy   high whenever a transaction is in progress
module sr_ff_access_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] op,
  input  logic            Q,
  output logic            S,
  output logic            R,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] ack,
  output logic            err,
  output logic            busy
);

  localparam int unsigned PW          = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [2:0]  RETRY_LIMIT = 3'(MAX_RETRY);
  localparam logic [PW-1:0] LAST_IDX  = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK,
    ACK
  } state_t;

  state_t          state, next_state;
  logic [PW-1:0]   ptr, next_ptr;
  logic [PW-1:0]   owner, next_owner;
  logic            target, next_target;
  logic [2:0]      retry, next_retry;

  logic            next_s, next_r;
  logic [NREQ-1:0] next_grant, next_ack;
  logic            next_err, next_busy;

  // Round-robin pick: first requester with req high, scanning upward from
  // ptr with wrap-around.
  logic            found;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   cidx;
  int unsigned     cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    cidx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cidx = PW'(cand);
      if (!found && req[cidx]) begin
        found = 1'b1;
        pick  = cidx;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      target <= 1'b0;
      retry  <= '0;
      S      <= 1'b0;
      R      <= 1'b0;
      grant  <= '0;
      ack    <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= next_state;
      ptr    <= next_ptr;
      owner  <= next_owner;
      target <= next_target;
      retry  <= next_retry;
      S      <= next_s;
      R      <= next_r;
      grant  <= next_grant;
      ack    <= next_ack;
      err    <= next_err;
      busy   <= next_busy;
    end
  end

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered, so that they line up with that state once registered.
  always_comb begin
    next_state  = state;
    next_ptr    = ptr;
    next_owner  = owner;
    next_target = target;
    next_retry  = retry;
    next_s      = 1'b0;
    next_r      = 1'b0;
    next_grant  = grant;
    next_ack    = '0;
    next_err    = 1'b0;

    unique case (state)
      IDLE: begin
        next_grant = '0;
        if (found) begin
          next_state        = DRIVE;
          next_owner        = pick;
          next_target       = op[pick];
          next_retry        = '0;
          next_s            = op[pick];
          next_r            = ~op[pick];
          next_grant[pick]  = 1'b1;
        end
      end

      DRIVE: begin
        next_state = CHECK;
      end

      CHECK: begin
        if (Q == target) begin
          next_state = ACK;
          next_ack   = grant;
        end else if (retry < RETRY_LIMIT) begin
          next_state = DRIVE;
          next_retry = retry + 3'd1;
          next_s     = target;
          next_r     = ~target;
        end else begin
          next_state = ACK;
          next_ack   = grant;
          next_err   = 1'b1;
        end
      end

      ACK: begin
        next_state = IDLE;
        next_grant = '0;
        next_ptr   = (owner == LAST_IDX) ? '0 : owner + PW'(1);
      end

      default: begin
        next_state = IDLE;
        next_grant = '0;
      end
    endcase

    next_busy = (next_state != IDLE);
  end

endmodule
